// File: rtl/sram_arbiter_pkg.sv
// Shared types and encodings for the two-port SRAM controller arbiter.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/sram_arbiter_rr_arbiter2.sv
// Combinational two-input picker: one-hot grant from req, last grant and priority mode.
module rr_arbiter2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            // On a tie the port that did not win last time goes next, unless port 0 is fixed-priority.
            if ((FIXED_PRIO != 0) || last_grant) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the data-cache (port 0) and instruction-fetch (port 1) requesters onto one SRAM controller.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WDATA_W    = 32,
    parameter int RDATA_W    = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en_0,
    input  logic               wr_en_0,
    input  logic [ADDR_W-1:0]  addr_0,
    input  logic [WDATA_W-1:0] wdata_0,
    output logic               ready_0,
    output logic [RDATA_W-1:0] rdata_0,
    input  logic               rd_en_1,
    input  logic               wr_en_1,
    input  logic [ADDR_W-1:0]  addr_1,
    input  logic [WDATA_W-1:0] wdata_1,
    output logic               ready_1,
    output logic [RDATA_W-1:0] rdata_1,
    output logic               sram_rd_en,
    output logic               sram_wr_en,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [WDATA_W-1:0] sram_wdata,
    input  logic               sram_ready,
    input  logic [RDATA_W-1:0] sram_rdata,
    output logic               busy
);

    state_t              state_reg, state_next;
    logic                gnt_reg, gnt_next;
    logic                op_reg, op_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [WDATA_W-1:0]  wdata_reg, wdata_next;
    logic [RDATA_W-1:0]  rdata_reg, rdata_next;
    logic                last_grant_reg, last_grant_next;
    logic [1:0]          req;
    logic [1:0]          pick;

    assign req = {rd_en_1 | wr_en_1, rd_en_0 | wr_en_0};

    rr_arbiter2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_pick (
        .req       (req),
        .last_grant(last_grant_reg),
        .gnt       (pick)
    );

    always_comb begin
        state_next      = state_reg;
        gnt_next        = gnt_reg;
        op_next         = op_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (|pick) begin
                    // A write enable dominates, so rd+wr on one port becomes a write.
                    gnt_next        = pick[1];
                    op_next         = pick[1] ? (wr_en_1 ? OP_WR : OP_RD) : (wr_en_0 ? OP_WR : OP_RD);
                    addr_next       = pick[1] ? addr_1 : addr_0;
                    wdata_next      = pick[1] ? wdata_1 : wdata_0;
                    last_grant_next = pick[1];
                    state_next      = BUSY;
                end
            end
            BUSY: begin
                if (sram_ready) begin
                    if (op_reg == OP_RD) begin
                        rdata_next = sram_rdata;
                    end
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            gnt_reg        <= 1'b0;
            op_reg         <= OP_RD;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            gnt_reg        <= gnt_next;
            op_reg         <= op_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Every output decodes registered state only.
    assign sram_rd_en = (state_reg == BUSY) && (op_reg == OP_RD);
    assign sram_wr_en = (state_reg == BUSY) && (op_reg == OP_WR);
    assign sram_addr  = addr_reg;
    assign sram_wdata = wdata_reg;
    assign ready_0    = (state_reg == ACK) && !gnt_reg;
    assign ready_1    = (state_reg == ACK) && gnt_reg;
    assign rdata_0    = rdata_reg;
    assign rdata_1    = rdata_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed vectors run against a round-robin (dut0) and a fixed-priority (dut1) arbiter sharing stimulus.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        rd_en_0, wr_en_0, rd_en_1, wr_en_1;
    logic [31:0] addr_0, addr_1, wdata_0, wdata_1;
    logic        sram_ready;
    logic [63:0] sram_rdata;

    logic        ready_0 [2];
    logic        ready_1 [2];
    logic [63:0] rdata_0 [2];
    logic [63:0] rdata_1 [2];
    logic        sram_rd_en [2];
    logic        sram_wr_en [2];
    logic [31:0] sram_addr [2];
    logic [31:0] sram_wdata [2];
    logic        busy [2];

    int n_cmp;
    int n_err;
    logic [63:0] exp_rdata [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            sram_arbiter #(
                .ADDR_W(32), .WDATA_W(32), .RDATA_W(64), .FIXED_PRIO(gi)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .rd_en_0   (rd_en_0),
                .wr_en_0   (wr_en_0),
                .addr_0    (addr_0),
                .wdata_0   (wdata_0),
                .ready_0   (ready_0[gi]),
                .rdata_0   (rdata_0[gi]),
                .rd_en_1   (rd_en_1),
                .wr_en_1   (wr_en_1),
                .addr_1    (addr_1),
                .wdata_1   (wdata_1),
                .ready_1   (ready_1[gi]),
                .rdata_1   (rdata_1[gi]),
                .sram_rd_en(sram_rd_en[gi]),
                .sram_wr_en(sram_wr_en[gi]),
                .sram_addr (sram_addr[gi]),
                .sram_wdata(sram_wdata[gi]),
                .sram_ready(sram_ready),
                .sram_rdata(sram_rdata),
                .busy      (busy[gi])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rd0, wr0, rd1, wr1;
        logic [31:0] addr0, addr1, wdata0, wdata1;
        int          lat;
        logic [63:0] srdata;
        logic        port_rr, port_fp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_busy"}, d, 64'(busy[d]), 64'd0);
            chk({tag, "_ready0"}, d, 64'(ready_0[d]), 64'd0);
            chk({tag, "_ready1"}, d, 64'(ready_1[d]), 64'd0);
            chk({tag, "_rd_en"}, d, 64'(sram_rd_en[d]), 64'd0);
            chk({tag, "_wr_en"}, d, 64'(sram_wr_en[d]), 64'd0);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        logic p, wr;
        logic [31:0] ea, ew;
        v = vecs[i];
        @(negedge clk);
        rd_en_0 = v.rd0; wr_en_0 = v.wr0; addr_0 = v.addr0; wdata_0 = v.wdata0;
        rd_en_1 = v.rd1; wr_en_1 = v.wr1; addr_1 = v.addr1; wdata_1 = v.wdata1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            p  = (d == 0) ? v.port_rr : v.port_fp;
            wr = p ? v.wr1 : v.wr0;
            ea = p ? v.addr1 : v.addr0;
            ew = p ? v.wdata1 : v.wdata0;
            chk("grant_busy", d, 64'(busy[d]), 64'd1);
            chk("grant_rd_en", d, 64'(sram_rd_en[d]), 64'(!wr));
            chk("grant_wr_en", d, 64'(sram_wr_en[d]), 64'(wr));
            chk("grant_addr", d, 64'(sram_addr[d]), 64'(ea));
            chk("grant_wdata", d, 64'(sram_wdata[d]), 64'(ew));
            chk("busy_ready0", d, 64'(ready_0[d]), 64'd0);
            chk("busy_ready1", d, 64'(ready_1[d]), 64'd0);
        end
        // Requester fields move while the command is in flight; the latched copy must not.
        addr_0 = 32'h0000_0800; addr_1 = 32'h0000_0900;
        wdata_0 = 32'h5555_AAAA; wdata_1 = 32'hAAAA_5555;
        repeat (v.lat - 1) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            p  = (d == 0) ? v.port_rr : v.port_fp;
            wr = p ? v.wr1 : v.wr0;
            chk("hold_addr", d, 64'(sram_addr[d]), 64'(p ? v.addr1 : v.addr0));
            chk("hold_wdata", d, 64'(sram_wdata[d]), 64'(p ? v.wdata1 : v.wdata0));
            chk("hold_en", d, 64'({sram_rd_en[d], sram_wr_en[d]}), 64'({!wr, wr}));
        end
        sram_ready = 1'b1;
        sram_rdata = v.srdata;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            p  = (d == 0) ? v.port_rr : v.port_fp;
            wr = p ? v.wr1 : v.wr0;
            if (!wr) exp_rdata[d] = v.srdata;
            chk("ack_ready0", d, 64'(ready_0[d]), 64'(p == 1'b0));
            chk("ack_ready1", d, 64'(ready_1[d]), 64'(p == 1'b1));
            chk("ack_rdata0", d, rdata_0[d], exp_rdata[d]);
            chk("ack_rdata1", d, rdata_1[d], exp_rdata[d]);
            chk("ack_en", d, 64'({sram_rd_en[d], sram_wr_en[d]}), 64'd0);
            chk("ack_busy", d, 64'(busy[d]), 64'd1);
        end
        $display("txn %0d: dut0 port %0d ready=%b%b  dut1 port %0d ready=%b%b  rdata %h/%h",
                 i, v.port_rr, ready_1[0], ready_0[0], v.port_fp, ready_1[1], ready_0[1],
                 rdata_0[0], rdata_0[1]);
        rd_en_0 = 1'b0; wr_en_0 = 1'b0; rd_en_1 = 1'b0; wr_en_1 = 1'b0;
        @(negedge clk);
        sram_ready = 1'b0;
        @(posedge clk); #1;
        chk_idle("post");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        rst = 1'b0;
        rd_en_0 = 1'b0; wr_en_0 = 1'b0; rd_en_1 = 1'b0; wr_en_1 = 1'b0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
        sram_ready = 1'b0;
        sram_rdata = '0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 32'h0, 5, 64'h1122334455667788, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 64'hFFFF0000FFFF0000, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 32'hA0A0A0A0, 32'hB1B1B1B1, 2, 64'hA, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 32'hA0A0A0A0, 32'hB1B1B1B1, 2, 64'hB, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 32'hA0A0A0A0, 32'hB1B1B1B1, 2, 64'hC, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 32'hA0A0A0A0, 32'hB1B1B1B1, 2, 64'hD, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 32'h0, 2, 64'hEEEE, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h50, 32'h12345678, 32'h0, 1, 64'h0123456789ABCDEF, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h60, 32'h70, 32'h0, 32'h0, 4, 64'h77, 1'b0, 1'b0};

        #1;
        chk_idle("reset");
        for (int d = 0; d < 2; d++) begin
            chk("reset_addr", d, 64'(sram_addr[d]), 64'd0);
            chk("reset_wdata", d, 64'(sram_wdata[d]), 64'd0);
            chk("reset_rdata", d, rdata_0[d], 64'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i);

        // sram_ready while IDLE must not start an acknowledge.
        @(negedge clk);
        sram_ready = 1'b1;
        sram_rdata = 64'hBAD0BAD0BAD0BAD0;
        @(posedge clk); #1;
        chk_idle("stray");
        for (int d = 0; d < 2; d++) chk("stray_rdata", d, rdata_0[d], exp_rdata[d]);
        @(negedge clk);
        sram_ready = 1'b0;

        // Asynchronous reset in the middle of a BUSY read.
        @(negedge clk);
        rd_en_0 = 1'b1;
        addr_0 = 32'h440;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) chk("pre_rst_busy", d, 64'(busy[d]), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("async_rst");
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_addr", d, 64'(sram_addr[d]), 64'd0);
            chk("async_rst_rdata", d, rdata_0[d], 64'd0);
            exp_rdata[d] = '0;
        end
        rd_en_0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_vec(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

- Shares the single SRAM controller between two requesters:
  - port 0: data-side cache controller.
  - port 1: instruction-fetch miss path.
- Accepts read/write requests and arbitrates them (round-robin or fixed priority).
- Registers the winner's command and holds it on the SRAM controller interface until the controller signals ready.
- Returns a one-cycle ready pulse with registered read data to the winning port.
- Sits between the cache/fetch logic and the SRAM controller, replacing the direct cache-to-controller connection.

## Interface
Parameters:
- ADDR_W, 32, request/SRAM address width
- WDATA_W, 32, write data width
- RDATA_W, 64, read line width returned by SRAM controller
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

Ports:
- Clocking and reset
  - clk  in  1  single clock; all state on rising edge
  - rst  in  1  asynchronous, active-low reset
- Requester ports (p = 0, 1)
  - rd_en_p  in  1  read request; held until ready_p
  - wr_en_p  in  1  write request; held until ready_p
  - addr_p  in  ADDR_W  request address
  - wdata_p  in  WDATA_W  write data
  - ready_p  out  1  one-cycle completion pulse
  - rdata_p  out  RDATA_W  read line; valid when ready_p=1 after a read
- SRAM controller side
  - sram_rd_en  out  1  read command to SRAM controller
  - sram_wr_en  out  1  write command to SRAM controller
  - sram_addr  out  ADDR_W  latched address
  - sram_wdata  out  WDATA_W  latched write data
  - sram_ready  in  1  controller completion pulse
  - sram_rdata  in  RDATA_W  controller read line
- Status
  - busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE
  - req_p = rd_en_p | wr_en_p.
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting:
    - FIXED_PRIO=1: port 0 wins.
    - FIXED_PRIO=0: the port not equal to last_grant wins.
  - On grant, latch into command registers: gnt, op (write if wr_en_p, else read), addr_p, wdata_p. Update last_grant. Go to BUSY.
- BUSY
  - Drive sram_rd_en = (op==read), sram_wr_en = (op==write).
  - sram_addr/sram_wdata come from the latched registers.
  - Requester inputs are ignored in this state; changing them has no effect.
  - On sram_ready: capture sram_rdata into rdata_reg, go to ACK.
- ACK
  - ready_gnt = 1 for exactly this cycle; the other port's ready stays 0.
  - sram_rd_en = sram_wr_en = 0.
  - Always return to IDLE.
  - The requester must drop its request on the ready cycle. A request still high in IDLE is treated as a new request.
- rdata_p
  - Both ports always output rdata_reg; a port samples it only on its own ready_p.
  - After a write, rdata_reg keeps its previous value.
- Illegal case: rd_en_p and wr_en_p both high on one port resolves as a write.
- sram_ready outside BUSY is ignored.
- Reset (rst=0, at any time, including mid-BUSY)
  - Outputs: state=IDLE, all sram_* enables=0, sram_addr=0, sram_wdata=0, ready_p=0, rdata_reg=0, busy=0.
  - last_grant=1, so port 0 wins the first tie.
  - The SRAM controller shares this reset; no aborted transaction is replayed.

## Timing
- Grant latency:
  - Request first high at edge t (state IDLE) → state BUSY after edge t.
  - sram_*_en high from cycle t+1.
- sram_ready high in cycle k → ready_p and rdata_p valid in cycle k+1 → IDLE in cycle k+2.
- End-to-end: requester ready arrives 2 cycles after the SRAM controller's own latency. Back-to-back grants are spaced by at least 3 cycles (BUSY ≥1, ACK, IDLE).
- Ready pulse: ready_p is exactly one cycle wide per accepted request; no pulse without a grant.
- Timing of outputs:
  - All outputs are registered or decoded from registered state only.
  - No combinational path exists from requester inputs to sram_* outputs.
  - No combinational path exists from sram_ready to ready_p.
- Fairness: with FIXED_PRIO=0 and both ports continuously requesting, grants strictly alternate.

## Structure
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, BUSY=2'd1, ACK=2'd2
  - op encoding: OP_RD=1'b0, OP_WR=1'b1
- One natural sub-module: rr_arbiter2. It is a combinational 2-input picker taking req[1:0], last_grant and FIXED_PRIO, and producing a one-hot grant.
- The FSM and command registers live in sram_arbiter itself.

## Test plan
- Single read, port 0:
  - Stimulus: rd_en_0=1, addr_0=0x0000_0400; controller returns sram_ready 5 cycles after sram_rd_en rises, with rdata 0x1122334455667788.
  - Required: sram_addr=0x400; ready_0 pulses one cycle later with rdata_0=0x1122334455667788; ready_1 stays 0.
- Single write, port 1:
  - Stimulus: wr_en_1=1, addr_1=0x10, wdata_1=0xDEADBEEF.
  - Required: sram_wr_en=1, sram_wdata=0xDEADBEEF until sram_ready; then ready_1 pulses once; rdata_reg unchanged.
- Tie with FIXED_PRIO=0, both ports requesting continuously for 4 transactions:
  - Required: grant order 0,1,0,1 (first tie after reset goes to port 0).
  - Required: FIXED_PRIO=1 gives 0,0,0,0 while port 0 keeps requesting.
- Input change during BUSY:
  - Stimulus: addr_0 changes to 0x800 mid-BUSY.
  - Required: sram_addr stays at the latched 0x400; a stray sram_ready in IDLE is ignored.
- Reset mid-transaction:
  - Stimulus: assert rst=0 asynchronously (between clock edges) during BUSY.
  - Required: sram_rd_en=0, busy=0, ready_p=0 immediately; after release, the first tie grants port 0.
- Illegal request:
  - Stimulus: rd_en_0=wr_en_0=1.
  - Required: a write is issued (sram_wr_en=1, sram_rd_en=0).
